// File: rtl/hps_status.sv
// hps_status: read-only Avalon-MM status slave for the rotor/frame logic.
// Measures clk cycles between falling edges of turn_tick, counts turns and
// new_frame requests, and flags counter saturation with a sticky ovf bit.
// Optional build macro: HPS_STATUS_TICK_SYNC_EN puts turn_tick through a
// 2-flop synchronizer before edge detection (adds 2 cycles of latency).
module hps_status #(
    parameter int unsigned R_ADDR_WIDTH = 2,
    parameter int unsigned R_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    turn_tick,
    input  logic                    new_frame,
    input  logic [R_ADDR_WIDTH-1:0] r_addr,
    input  logic                    r_enable,
    output logic [R_DATA_WIDTH-1:0] r_data,
    output logic                    r_valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_TURNS  = 2'd2;
    localparam logic [1:0] ADDR_FRAMES = 2'd3;

    localparam logic [R_DATA_WIDTH-1:0] CNT_MAX     = {R_DATA_WIDTH{1'b1}};
    localparam logic [R_DATA_WIDTH-1:0] CNT_ONE     = R_DATA_WIDTH'(1);
    localparam logic [R_DATA_WIDTH-1:0] CNT_PRE_MAX = CNT_MAX - CNT_ONE;

    logic                    tick_cur;
    logic                    tick_prev;
    logic                    nf_prev;
    logic                    fall;
    logic                    rise_nf;

    logic [1:0]              state;
    logic [1:0]              state_next;
    logic                    period_valid;

    logic [R_DATA_WIDTH-1:0] cnt;
    logic [R_DATA_WIDTH-1:0] cnt_next;
    logic [R_DATA_WIDTH-1:0] turn_period;
    logic [R_DATA_WIDTH-1:0] period_next;
    logic [R_DATA_WIDTH-1:0] turn_count;
    logic [R_DATA_WIDTH-1:0] frame_count;
    logic                    ovf;
    logic                    ovf_set;
    logic                    ovf_next;
    logic                    status_rd;

    logic [2:0]              status_bits;
    logic [R_DATA_WIDTH-1:0] rd_mux;

`ifdef HPS_STATUS_TICK_SYNC_EN
    logic tick_meta;
    logic tick_sync;

    // Two-flop synchronizer for the asynchronous hall-sensor tick
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tick_meta <= 1'b0;
            tick_sync <= 1'b0;
        end else begin
            tick_meta <= turn_tick;
            tick_sync <= tick_meta;
        end
    end

    assign tick_cur = tick_sync;
`else
    assign tick_cur = turn_tick;
`endif

    // Previous-value flops for tick and new_frame edge detection
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tick_prev <= 1'b0;
            nf_prev   <= 1'b0;
        end else begin
            tick_prev <= tick_cur;
            nf_prev   <= new_frame;
        end
    end

    assign fall    = tick_prev & ~tick_cur;
    assign rise_nf = ~nf_prev & new_frame;

    // Measurement FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign period_valid = (state == ST_VALID);

    // Next state plus period counter / overflow next values
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        period_next = turn_period;
        ovf_set     = 1'b0;
        case (state)
            ST_IDLE: begin
                // First edge only starts the stopwatch; no period yet.
                if (fall) begin
                    cnt_next   = CNT_ONE;
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED, ST_VALID: begin
                if (fall) begin
                    period_next = cnt;
                    cnt_next    = CNT_ONE;
                    state_next  = ST_VALID;
                end else if (cnt != CNT_MAX) begin
                    cnt_next = cnt + CNT_ONE;
                    ovf_set  = (cnt == CNT_PRE_MAX);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign status_rd = r_enable & (r_addr[1:0] == ADDR_STATUS);
    // A new saturation outranks the clear-on-read of STATUS.
    assign ovf_next  = ovf_set ? 1'b1 : (status_rd ? 1'b0 : ovf);

    // Period, turn/frame counters and sticky overflow
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt         <= '0;
            turn_period <= '0;
            turn_count  <= '0;
            frame_count <= '0;
            ovf         <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            turn_period <= period_next;
            ovf         <= ovf_next;
            if (fall) begin
                turn_count <= turn_count + CNT_ONE;
            end
            if (rise_nf) begin
                frame_count <= frame_count + CNT_ONE;
            end
        end
    end

    assign status_bits = {ovf, period_valid, tick_cur};

    // Register map decode; values are pre-update for the current cycle
    always_comb begin
        rd_mux = '0;
        case (r_addr[1:0])
            ADDR_STATUS: rd_mux = R_DATA_WIDTH'(status_bits);
            ADDR_PERIOD: rd_mux = turn_period;
            ADDR_TURNS:  rd_mux = turn_count;
            ADDR_FRAMES: rd_mux = frame_count;
            default:     rd_mux = '0;
        endcase
    end

    // Fixed one-cycle read response; data holds between reads
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_enable;
            if (r_enable) begin
                r_data <= rd_mux;
            end
        end
    end

endmodule
